// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX stage (req0, high priority) and the aux sequencer (req1); aging counter stops req1 from being starved.
// Latency: request accepted at edge N, response pulse in cycle N+2; one operation every 2 cycles.
// Backpressure: a requester holds valid until its ready; ready only in IDLE. ALU_ARB_GRANT_CNT_EN adds per-requester grant counters.
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int MAX_WAIT   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_vld,
    output logic                  req0_rdy,
    input  logic [CTRL_WIDTH-1:0] req0_ctrl,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_vld,
    output logic                  req1_rdy,
    input  logic [CTRL_WIDTH-1:0] req1_ctrl,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  rsp0_vld,
    output logic                  rsp1_vld,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t     state, state_nxt;
    logic       owner;
    logic [3:0] age1;
    logic       force1;
    logic       gnt0, gnt1;

    assign force1 = req1_vld && (age1 >= MAX_W);

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        case (state)
            IDLE: begin
                if (force1)
                    gnt1 = 1'b1;
                else if (req0_vld)
                    gnt0 = 1'b1;
                else if (req1_vld)
                    gnt1 = 1'b1;
                if (gnt0 || gnt1)
                    state_nxt = EXEC;
            end
            EXEC: state_nxt = IDLE;
        endcase
    end

    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= 1'b0;
            alu_control <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp0_vld    <= 1'b0;
            rsp1_vld    <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
        end else begin
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            if (gnt0) begin
                owner       <= 1'b0;
                alu_control <= req0_ctrl;
                alu_a       <= req0_a;
                alu_b       <= req0_b;
            end else if (gnt1) begin
                owner       <= 1'b1;
                alu_control <= req1_ctrl;
                alu_a       <= req1_a;
                alu_b       <= req1_b;
            end
            // ALU output settles during EXEC; capture it as we fall back to IDLE
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                if (owner)
                    rsp1_vld <= 1'b1;
                else
                    rsp0_vld <= 1'b1;
            end
        end
    end

    // Age only advances in IDLE cycles where req1 was refused; frozen during EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            age1 <= '0;
        else if (state == IDLE) begin
            if (!req1_vld || gnt1)
                age1 <= '0;
            else if (age1 < MAX_W)
                age1 <= age1 + 4'd1;
        end
    end

`ifdef ALU_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (gnt0)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (gnt1)
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table for single-cycle behaviour,
// hand-written sequences for starvation, reset during EXEC and grant counters.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic        req0_rdy, req1_rdy;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_zero;
    logic        rsp0_vld, rsp1_vld;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [15:0] grant_cnt0, grant_cnt1;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32), .CTRL_WIDTH(4), .MAX_WAIT(7)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
        .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp0_vld(rsp0_vld), .rsp1_vld(rsp1_vld), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Stand-in for the shared ALU
    always_comb begin
        alu_result = 32'd0;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic        rsp0;
        logic        rsp1;
        logic [31:0] res;
        logic        z;
    } obs_t;

    typedef struct {
        logic        v0;
        logic [3:0]  c0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic        v1;
        logic [3:0]  c1;
        logic [31:0] a1;
        logic [31:0] b1;
        obs_t        exp;
    } vec_t;

    vec_t vecs[13];

    function automatic obs_t observe();
        obs_t o;
        o.rdy0 = req0_rdy;  o.rdy1 = req1_rdy;
        o.ctl  = alu_control; o.a = alu_a; o.b = alu_b;
        o.rsp0 = rsp0_vld;  o.rsp1 = rsp1_vld;
        o.res  = rsp_result; o.z = rsp_zero;
        return o;
    endfunction

    function automatic obs_t mk_obs(input logic r0, input logic r1, input logic [3:0] c,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic p0, input logic p1, input logic [31:0] res, input logic z);
        obs_t o;
        o.rdy0 = r0; o.rdy1 = r1; o.ctl = c; o.a = a; o.b = b;
        o.rsp0 = p0; o.rsp1 = p1; o.res = res; o.z = z;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_vld = 1'b0; req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_vld = 1'b0; req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    endtask

    // One full operation on an otherwise idle arbiter: accept, execute, respond
    task automatic do_op(input string nm, input logic who, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic z);
        if (who) begin
            req1_vld = 1'b1; req1_ctrl = c; req1_a = a; req1_b = b;
        end else begin
            req0_vld = 1'b1; req0_ctrl = c; req0_a = a; req0_b = b;
        end
        @(negedge clk);
        chk({nm, " accept"}, 128'({req0_rdy, req1_rdy}), 128'({~who, who}));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({nm, " alu bus"}, 128'({alu_control, alu_a, alu_b}), 128'({c, a, b}));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, " rsp"}, 128'({rsp0_vld, rsp1_vld, rsp_result, rsp_zero}), 128'({~who, who, res, z}));
        @(posedge clk); #1;
    endtask

    initial begin
        logic grants[$];
        logic exp_gr[16];
        int   both;
        int   cyc;

        //                     v0 c0    a0      b0      v1 c1    a1     b1      rdy0 rdy1 ctl  a       b       rsp0 rsp1 res     z
        vecs[0]  = '{1'b1, 4'd2, 32'd5,  32'd7,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(1, 0, 4'd0, 32'd0,  32'd0,  0, 0, 32'd0,  0)};
        vecs[1]  = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd2, 32'd5,  32'd7,  0, 0, 32'd0,  0)};
        vecs[2]  = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd2, 32'd5,  32'd7,  1, 0, 32'd12, 0)};
        vecs[3]  = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b1, 4'd6, 32'd9, 32'd9, mk_obs(0, 1, 4'd2, 32'd5,  32'd7,  0, 0, 32'd12, 0)};
        vecs[4]  = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd6, 32'd9,  32'd9,  0, 0, 32'd12, 0)};
        vecs[5]  = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd6, 32'd9,  32'd9,  0, 1, 32'd0,  1)};
        vecs[6]  = '{1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0, mk_obs(1, 0, 4'd6, 32'd9,  32'd9,  0, 0, 32'd0,  1)};
        vecs[7]  = '{1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd1, 32'hF0, 32'h0F, 0, 0, 32'd0,  1)};
        vecs[8]  = '{1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0, mk_obs(1, 0, 4'd1, 32'hF0, 32'h0F, 1, 0, 32'hFF, 0)};
        vecs[9]  = '{1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd1, 32'hF0, 32'h0F, 0, 0, 32'hFF, 0)};
        vecs[10] = '{1'b1, 4'd1, 32'hF0, 32'h0F, 1'b0, 4'd0, 32'd0, 32'd0, mk_obs(1, 0, 4'd1, 32'hF0, 32'h0F, 1, 0, 32'hFF, 0)};
        vecs[11] = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd1, 32'hF0, 32'h0F, 0, 0, 32'hFF, 0)};
        vecs[12] = '{1'b0, 4'd0, 32'd0,  32'd0,  1'b0, 4'd0, 32'd0, 32'd0, mk_obs(0, 0, 4'd1, 32'hF0, 32'h0F, 1, 0, 32'hFF, 0)};

        rst = 1'b1;
        idle_inputs();
        #3;
        chk("reset outputs", 128'(observe()), 128'(mk_obs(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0)));
        chk("reset counters", 128'({grant_cnt0, grant_cnt1}), 128'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            req0_vld = vecs[i].v0; req0_ctrl = vecs[i].c0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
            req1_vld = vecs[i].v1; req1_ctrl = vecs[i].c1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
            @(negedge clk);
            chk($sformatf("vector %0d", i), 128'(observe()), 128'(vecs[i].exp));
            @(posedge clk); #1;
        end

        // Both requesters held valid: seven grants to 0, then one forced grant to 1
        for (int i = 0; i < 16; i++) exp_gr[i] = (i == 7 || i == 15);
        req0_vld = 1'b1; req0_ctrl = 4'd2; req0_a = 32'd1; req0_b = 32'd1;
        req1_vld = 1'b1; req1_ctrl = 4'd2; req1_a = 32'd3; req1_b = 32'd3;
        both = 0;
        cyc  = 0;
        while (grants.size() < 16 && cyc < 60) begin
            @(negedge clk);
            if (req0_rdy && req1_rdy) both++;
            else if (req0_rdy) grants.push_back(1'b0);
            else if (req1_rdy) grants.push_back(1'b1);
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        chk("starve both ready", 128'(both), 128'd0);
        if (grants.size() < 16) begin
            nvec++; nmis++;
            $display("FAIL starve timeout: got %0d grants expected 16", grants.size());
        end else begin
            for (int i = 0; i < 16; i++)
                chk($sformatf("starve grant %0d", i), 128'(grants[i]), 128'(exp_gr[i]));
        end
        repeat (3) begin @(posedge clk); #1; end

        // Reset while an operation is in EXEC
        req0_vld = 1'b1; req0_ctrl = 4'd2; req0_a = 32'd5; req0_b = 32'd7;
        @(negedge clk);
        chk("abort accept", 128'(req0_rdy), 128'd1);
        @(posedge clk); #1;
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        chk("abort async clear", 128'(observe()), 128'(mk_obs(0, 0, 4'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0)));
        @(posedge clk); #1;
        chk("abort no pulse", 128'({rsp0_vld, rsp1_vld}), 128'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("abort no late pulse", 128'({rsp0_vld, rsp1_vld, rsp_result}), 128'd0);
        @(posedge clk); #1;

        do_op("recover r1", 1'b1, 4'b0010, 32'd4, 32'd4, 32'd8, 1'b0);
        do_op("cnt r0 a",   1'b0, 4'b0001, 32'hF0, 32'h0F, 32'hFF, 1'b0);
        do_op("cnt r0 b",   1'b0, 4'b0000, 32'hF0, 32'h0F, 32'h0, 1'b1);
        do_op("cnt r0 c",   1'b0, 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0);
        do_op("cnt r1",     1'b1, 4'b0110, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0);
`ifdef ALU_ARB_GRANT_CNT_EN
        chk("grant counters", 128'({grant_cnt0, grant_cnt1}), 128'({16'd3, 16'd2}));
`else
        chk("grant counters", 128'({grant_cnt0, grant_cnt1}), 128'({16'd0, 16'd0}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU between two requesters.
  - Requester 0: main pipeline EX stage, high priority.
  - Requester 1: auxiliary sequencer (address/branch helper), low priority.
- Per-requester valid/ready request handshake; registers the granted operands onto the ALU input bus.
- Captures the ALU result and Zero flag; returns them to the winning requester as a one-cycle response pulse.
- An aging counter guarantees requester 1 cannot be starved.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match the ALU.
- CTRL_WIDTH, 4, ALU control code width.
- MAX_WAIT, 7, cycles requester 1 may be blocked before it is force-granted (1..15).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req0Valid  in  1  requester 0 has an operation pending.
- Req0Ready  out  1  requester 0 accepted this cycle.
- Req0Ctrl  in  CTRL_WIDTH  requester 0 ALU control code.
- Req0A, Req0B  in  DATA_WIDTH  requester 0 operands.
- Req1Valid, Req1Ready, Req1Ctrl, Req1A, Req1B: same as requester 0, for requester 1.
- AluControl  out  CTRL_WIDTH  registered control to the ALU.
- AluA, AluB  out  DATA_WIDTH  registered operands to the ALU.
- AluResult  in  DATA_WIDTH  ALU result (combinational from AluControl/AluA/AluB).
- AluZero  in  1  ALU Zero flag.
- Rsp0Valid  out  1  one-cycle pulse: response for requester 0.
- Rsp1Valid  out  1  one-cycle pulse: response for requester 1.
- RspResult  out  DATA_WIDTH  captured ALU result.
- RspZero  out  1  captured Zero flag.
- GrantCnt0, GrantCnt1  out  16  grant counters (see Optional Feature).

Behaviour:
- Reset (async, immediate): state IDLE; Age1=0; all outputs 0 (AluControl=0, AluA=0, AluB=0, Rsp*Valid=0, RspResult=0, RspZero=0).
- FSM states: IDLE, EXEC.
- IDLE:
  - ReqXReady is combinational and asserts only for the requester granted this cycle. At most one Ready per cycle.
  - Grant rule:
    - Req1Valid && Age1>=MAX_WAIT → grant 1.
    - Else Req0Valid → grant 0.
    - Else Req1Valid → grant 1.
    - Else no grant.
  - On grant, at the clock edge: AluControl/AluA/AluB load the granted request; owner flag records the requester; go to EXEC.
  - No grant → stay IDLE; Alu* outputs hold their last values.
- EXEC:
  - No Ready asserted.
  - At the edge: RspResult<=AluResult, RspZero<=AluZero, Rsp[owner]Valid<=1; go to IDLE.
- Rsp*Valid is high exactly one cycle, coinciding with the next IDLE cycle. A new grant may occur in that same cycle.
- Latency: accept edge N → response valid in cycle N+2.
- Throughput: one operation per 2 cycles.
- Requesters must hold Valid/Ctrl/A/B stable until Ready. The arbiter does not check this.
- Age1 (4-bit, saturates at MAX_WAIT):
  - +1 each IDLE cycle with Req1Valid high and Req1Ready low.
  - Cleared when requester 1 is granted or Req1Valid is low.
  - Held during EXEC.
- Ctrl codes pass through unchecked; undefined codes yield whatever the ALU produces.
- Simultaneous Req0Valid/Req1Valid with Age1<MAX_WAIT: requester 0 wins.
- Reset during EXEC: operation aborted, no response pulse, Age1 cleared.
- RspResult/RspZero hold between responses.

Optional Feature:
- Macro: ALU_ARB_GRANT_CNT_EN.
- Defined:
  - GrantCnt0/GrantCnt1 count grants to each requester.
  - Each counter is 16-bit, wraps 0xFFFF→0x0000, and resets to 0.
- Not defined: GrantCnt0/GrantCnt1 tied to 0; no counter flops.

Test Plan:
- Req0 only, Ctrl=0010, A=5, B=7 → Req0Ready in cycle 0; AluA=5/AluB=7 from cycle 1; Rsp0Valid pulse in cycle 2 with RspResult=12, RspZero=0.
- Req1 only, Ctrl=0110, A=9, B=9 → Rsp1Valid pulse 2 cycles after accept, RspResult=0, RspZero=1; Rsp0Valid stays 0.
- Req0 and Req1 both held valid continuously, MAX_WAIT=7 → grants to 0 until Age1 reaches 7, then one grant to 1, then Age1=0 and grants return to 0; no cycle has both Ready high.
- Back-to-back Req0 stream (Ctrl=0001, A=0xF0, B=0x0F) → accepts every 2nd cycle; each Rsp0Valid carries 0xFF and overlaps the next accept cycle.
- Reset asserted in EXEC mid-operation → all outputs 0 immediately, no Rsp pulse; after release, first request completes normally.
- With ALU_ARB_GRANT_CNT_EN, 3 grants to 0 and 2 to 1 → GrantCnt0=3, GrantCnt1=2. Without the macro → both read 0.
